data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit RAM words; must be a power of two, 16..65536.
REQ-002 Parameter LED_WIDTH, default 4, SHALL set the LED register width, 1..32.
REQ-003 Parameter MMIO_BASE, default 32'h8000_0000, SHALL set the MMIO window base: LED register at base+0, cycle counter at base+4.
REQ-004 Clocking SHALL be one clock and reset: synchronous, active-high.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req  input  1  access request, valid for one cycle.
REQ-008 we  input  1  1 = store, 0 = load; ignored when req=0.
REQ-009 funct3  input  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 addr  input  32  byte address.
REQ-011 wdata  input  32  store data, right-aligned.
REQ-012 rdata  output  32  load result, extended per funct3.
REQ-013 rvalid  output  1  one-cycle pulse: rdata valid.
REQ-014 err  output  1  one-cycle pulse: previous access faulted.
REQ-015 leds_out  output  LED_WIDTH  LED register contents.

Function
REQ-016 Load latency SHALL be exactly one cycle: req=1, we=0 at edge N -> rvalid=1 with rdata for cycle N+1, then rvalid=0 unless a further load.
REQ-017 Back-to-back loads SHALL be accepted every cycle at full throughput, with no stall and no ready signal.
REQ-018 Stores SHALL commit at the accepting edge and SHALL never assert rvalid.
REQ-019 Loads SHALL use the lane selected by addr[1:0]: B/BU sign/zero-extend bits [7:0] of that lane; H/HU use addr[1]; W returns the full word.
REQ-020 SB/SH SHALL modify only the addressed byte or half-word lanes; other lanes SHALL keep their value.
REQ-021 A misaligned access SHALL set err=1 in cycle N+1, suppress the write, and return rdata=0 with rvalid=1 for a load. Misaligned means: H/HU with addr[0]=1, or W with addr[1:0]!=0.
REQ-022 funct3 values 011, 110 and 111 SHALL be treated as faults with the same behaviour as REQ-021.
REQ-023 RAM SHALL be selected when addr[31:2] < DEPTH_WORDS; no address aliasing.
REQ-024 Addresses in neither RAM nor MMIO SHALL return rdata=0 with rvalid=1 on a load and SHALL ignore stores; err SHALL stay 0 for these.
REQ-025 LED register accesses:
- Store (any size) writes wdata[LED_WIDTH-1:0].
- Load returns the register zero-extended.
REQ-026 Cycle counter (base+4) SHALL be a read-only 32-bit counter, +1 per cycle, wrapping 0xFFFF_FFFF -> 0; stores to it SHALL be ignored.
REQ-027 A load of the counter SHALL return the value held at the accepting edge N.
REQ-028 Load-after-store to the same address in consecutive cycles SHALL return the newly stored data.

Reset
REQ-029 While rst=1 at an edge, the block SHALL force rdata=0, rvalid=0, err=0, leds_out=0 and counter=0.
REQ-030 RAM contents SHALL NOT be reset.
REQ-031 A load accepted in the same cycle as rst=1 SHALL be dropped: no rvalid pulse after reset deasserts.
REQ-032 A store accepted in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-033 Macro DMEM_CYCLE_COUNTER_EN: when defined, the counter of REQ-026 exists.
REQ-034 When DMEM_CYCLE_COUNTER_EN is undefined, the counter SHALL not be synthesised and base+4 SHALL behave as an unmapped address per REQ-024.

Verification
REQ-035 SW 0x1234_5678 @0x10, then LW @0x10 -> next cycle rvalid=1, rdata=0x1234_5678.
REQ-036 After REQ-035, SB 0xAB @0x11, then LB @0x11 -> rdata=0xFFFF_FFAB; LBU @0x11 -> rdata=0x0000_00AB; LW @0x10 -> rdata=0x1234_AB78.
REQ-037 LH @0x13 -> rvalid=1, err=1, rdata=0. SW 0xFFFF_FFFF @0x12 -> err=1 and word @0x10 unchanged.
REQ-038 SW 0x0000_000F @MMIO_BASE -> leds_out=0xF. Then assert rst -> leds_out=0, rvalid=0, and LW @0x10 still returns 0x1234_AB78.
REQ-039 With DMEM_CYCLE_COUNTER_EN defined, two LWs @MMIO_BASE+4 issued 5 cycles apart -> values differ by 5. With the macro undefined -> rdata=0, err=0.
REQ-040 LW issued every cycle to 0x0,0x4,0x8 -> rvalid high for 3 consecutive cycles carrying the three stored words in order.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte-addressable RAM, LED register and cycle counter behind a one-cycle load pipeline.
// Optional feature: define DMEM_CYCLE_COUNTER_EN to map the cycle counter at MMIO_BASE+4.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LED_WIDTH   = 4,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [2:0]           funct3,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 rvalid,
    output logic                 err,
    output logic [LED_WIDTH-1:0] leds_out
);
    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [29:0] LED_WORD = MMIO_BASE[31:2];

    logic [31:0]          mem [DEPTH_WORDS];
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 err_q, err_d;
    logic [LED_WIDTH-1:0] leds_q, leds_d;
    logic                 mem_we;
    logic [3:0]           mem_be;
    logic [31:0]          mem_wdata;
    logic [AW-1:0]        word_idx;
    logic [31:0]          ram_word;
    logic [7:0]           lane_byte;
    logic [15:0]          lane_half;
    logic                 size_ok, misaligned, ram_sel, led_sel;

    assign word_idx  = addr[AW+1:2];
    assign ram_sel   = {2'b00, addr[31:2]} < 32'(DEPTH_WORDS);
    assign led_sel   = addr[31:2] == LED_WORD;
    assign ram_word  = mem[word_idx];
    assign lane_half = addr[1] ? ram_word[31:16] : ram_word[15:0];

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] counter_q, counter_d;
    logic        cnt_sel;

    assign cnt_sel = addr[31:2] == LED_WORD + 30'd1;

    always_comb begin
        counter_d = counter_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) counter_q <= '0;
        else     counter_q <= counter_d;
    end
`endif

    always_comb begin
        size_ok    = 1'b1;
        misaligned = 1'b0;
        case (funct3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = addr[0];
            3'b010:         misaligned = addr[1:0] != 2'b00;
            default:        size_ok    = 1'b0;
        endcase
    end

    always_comb begin
        lane_byte = ram_word[7:0];
        case (addr[1:0])
            2'b01:   lane_byte = ram_word[15:8];
            2'b10:   lane_byte = ram_word[23:16];
            2'b11:   lane_byte = ram_word[31:24];
            default: lane_byte = ram_word[7:0];
        endcase
    end

    // Faults take priority over address decode; unmapped accesses are silent.
    always_comb begin
        rdata_d   = '0;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        leds_d    = leds_q;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = wdata;
        if (req && !rst) begin
            if (!size_ok || misaligned) begin
                err_d    = 1'b1;
                rvalid_d = !we;
            end else if (we) begin
                if (ram_sel) begin
                    mem_we = 1'b1;
                    case (funct3[1:0])
                        2'b00: begin
                            mem_be    = 4'b0001 << addr[1:0];
                            mem_wdata = {4{wdata[7:0]}};
                        end
                        2'b01: begin
                            mem_be    = addr[1] ? 4'b1100 : 4'b0011;
                            mem_wdata = {2{wdata[15:0]}};
                        end
                        default: mem_be = 4'b1111;
                    endcase
                end else if (led_sel) begin
                    leds_d = wdata[LED_WIDTH-1:0];
                end
            end else begin
                rvalid_d = 1'b1;
                if (ram_sel) begin
                    case (funct3)
                        3'b000:  rdata_d = {{24{lane_byte[7]}}, lane_byte};
                        3'b100:  rdata_d = {24'd0, lane_byte};
                        3'b001:  rdata_d = {{16{lane_half[15]}}, lane_half};
                        3'b101:  rdata_d = {16'd0, lane_half};
                        default: rdata_d = ram_word;
                    endcase
                end else if (led_sel) begin
                    rdata_d = 32'(leds_q);
                end
`ifdef DMEM_CYCLE_COUNTER_EN
                else if (cnt_sel) begin
                    rdata_d = counter_q;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            leds_q   <= '0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            leds_q   <= leds_d;
        end
    end

    // RAM contents survive reset; only the byte lanes selected by mem_be change.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[word_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign err      = err_q;
    assign leds_out = leds_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized accesses against a byte-array model.
// Define DMEM_CYCLE_COUNTER_EN for both files to exercise the cycle counter.
module tb_data_mem_ctrl;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    logic        rvalid, err;
    logic [3:0]  leds_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]  got_rd;
    logic         got_rv, got_err;
    byte unsigned ref_mem [4096];
    logic [3:0]   ref_leds = 4'h0;

    always #5 clk = ~clk;

    data_mem_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
        .err(err), .leds_out(leds_out)
    );

    // Called at a falling edge: drive one request, then capture the response one cycle later.
    task automatic step(input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
        req = r; we = w; funct3 = f3; addr = a; wdata = d;
        @(negedge clk);
        got_rd = rdata; got_rv = rvalid; got_err = err;
    endtask

    // Reference model: byte-granular memory, sizes derived from funct3, alignment by modulo.
    task automatic model_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, output logic e_rv, output logic e_err,
                                output logic [31:0] e_rd);
        int size;
        logic [31:0] val;
        e_rv = 1'b0; e_err = 1'b0; e_rd = 32'h0;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        if (size == 0 || (a % size) != 0) begin
            e_err = 1'b1;
            e_rv  = !w;
        end else if (w) begin
            if (a < 32'd4096) begin
                for (int k = 0; k < size; k++) ref_mem[int'(a) + k] = d[8*k +: 8];
            end else if (a[31:2] == BASE[31:2]) begin
                ref_leds = d[3:0];
            end
        end else begin
            e_rv = 1'b1;
            if (a < 32'd4096) begin
                val = 32'h0;
                for (int k = 0; k < size; k++) val = val | (32'(ref_mem[int'(a) + k]) << (8 * k));
                if (!f3[2] && size == 1) val = {{24{val[7]}}, val[7:0]};
                if (!f3[2] && size == 2) val = {{16{val[15]}}, val[15:0]};
                e_rd = val;
            end else if (a[31:2] == BASE[31:2]) begin
                e_rd = {28'h0, ref_leds};
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        n_tests++;
        if (got_rv !== 1'b0 || got_err !== 1'b0 || got_rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: rvalid=%b err=%b rdata=%h, expected 0 0 00000000", got_rv, got_err, got_rd);
        end
        step(1'b1, 1'b1, 3'b010, BASE, 32'hF);
        n_tests++;
        if (leds_out !== 4'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_store_ignored: leds=%h, expected 0", leds_out);
        end
        rst = 1'b0;
        step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        n_tests++;
        if (got_rv !== 1'b0 || got_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_load_dropped: rvalid=%b err=%b, expected 0 0", got_rv, got_err);
        end
    endtask

    task automatic test_ram_lanes();
        step(1'b1, 1'b1, 3'b010, 32'h10, 32'h1234_5678);
        n_tests++;
        if (got_rv !== 1'b0 || got_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sw_no_rvalid: rvalid=%b err=%b, expected 0 0", got_rv, got_err);
        end
        step(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        n_tests++;
        if (got_rv !== 1'b1 || got_rd !== 32'h1234_5678) begin
            n_fail++;
            $display("[TB] FAIL lw_0x10: rvalid=%b rdata=%h, expected 1 12345678", got_rv, got_rd);
        end
        step(1'b1, 1'b1, 3'b000, 32'h11, 32'h0000_00AB);
        step(1'b1, 1'b0, 3'b000, 32'h11, 32'h0);
        n_tests++;
        if (got_rv !== 1'b1 || got_rd !== 32'hFFFF_FFAB) begin
            n_fail++;
            $display("[TB] FAIL lb_0x11: rvalid=%b rdata=%h, expected 1 ffffffab", got_rv, got_rd);
        end
        step(1'b1, 1'b0, 3'b100, 32'h11, 32'h0);
        n_tests++;
        if (got_rd !== 32'h0000_00AB) begin
            n_fail++;
            $display("[TB] FAIL lbu_0x11: rdata=%h, expected 000000ab", got_rd);
        end
        step(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        n_tests++;
        if (got_rd !== 32'h1234_AB78) begin
            n_fail++;
            $display("[TB] FAIL lw_after_sb: rdata=%h, expected 1234ab78", got_rd);
        end
        step(1'b1, 1'b0, 3'b001, 32'h13, 32'h0);
        n_tests++;
        if (got_rv !== 1'b1 || got_err !== 1'b1 || got_rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL lh_misaligned: rvalid=%b err=%b rdata=%h, expected 1 1 00000000", got_rv, got_err, got_rd);
        end
        step(1'b1, 1'b1, 3'b010, 32'h12, 32'hFFFF_FFFF);
        n_tests++;
        if (got_rv !== 1'b0 || got_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL sw_misaligned: rvalid=%b err=%b, expected 0 1", got_rv, got_err);
        end
        step(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        n_tests++;
        if (got_err !== 1'b0 || got_rd !== 32'h1234_AB78) begin
            n_fail++;
            $display("[TB] FAIL sw_misaligned_suppressed: err=%b rdata=%h, expected 0 1234ab78", got_err, got_rd);
        end
        step(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
        n_tests++;
        if (got_rv !== 1'b1 || got_err !== 1'b1 || got_rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL bad_funct3: rvalid=%b err=%b rdata=%h, expected 1 1 00000000", got_rv, got_err, got_rd);
        end
    endtask

    task automatic test_mmio_and_reset();
        step(1'b1, 1'b1, 3'b010, BASE, 32'h0000_000F);
        n_tests++;
        if (leds_out !== 4'hF) begin
            n_fail++;
            $display("[TB] FAIL led_store: leds=%h, expected f", leds_out);
        end
        step(1'b1, 1'b0, 3'b010, BASE, 32'h0);
        n_tests++;
        if (got_rv !== 1'b1 || got_rd !== 32'h0000_000F) begin
            n_fail++;
            $display("[TB] FAIL led_load: rvalid=%b rdata=%h, expected 1 0000000f", got_rv, got_rd);
        end
        step(1'b1, 1'b0, 3'b010, 32'h4000_0000, 32'h0);
        n_tests++;
        if (got_rv !== 1'b1 || got_err !== 1'b0 || got_rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL unmapped_load: rvalid=%b err=%b rdata=%h, expected 1 0 00000000", got_rv, got_err, got_rd);
        end
        rst = 1'b1;
        step(1'b1, 1'b0, 3'b010, BASE, 32'h0);
        rst = 1'b0;
        n_tests++;
        if (leds_out !== 4'h0 || got_rv !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL led_reset: leds=%h rvalid=%b, expected 0 0", leds_out, got_rv);
        end
        step(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        n_tests++;
        if (got_rv !== 1'b1 || got_rd !== 32'h1234_AB78) begin
            n_fail++;
            $display("[TB] FAIL ram_survives_reset: rvalid=%b rdata=%h, expected 1 1234ab78", got_rv, got_rd);
        end
    endtask

    task automatic test_counter();
`ifdef DMEM_CYCLE_COUNTER_EN
        logic [31:0] v1;
        step(1'b1, 1'b0, 3'b010, BASE + 32'd4, 32'h0);
        v1 = got_rd;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step(1'b1, 1'b0, 3'b010, BASE + 32'd4, 32'h0);
        n_tests++;
        if (got_rv !== 1'b1 || got_err !== 1'b0 || (got_rd - v1) !== 32'd5) begin
            n_fail++;
            $display("[TB] FAIL counter_delta: rvalid=%b err=%b delta=%0d, expected 1 0 5", got_rv, got_err, got_rd - v1);
        end
`else
        step(1'b1, 1'b0, 3'b010, BASE + 32'd4, 32'h0);
        n_tests++;
        if (got_rv !== 1'b1 || got_err !== 1'b0 || got_rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL counter_absent: rvalid=%b err=%b rdata=%h, expected 1 0 00000000", got_rv, got_err, got_rd);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [3];
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            step(1'b1, 1'b1, 3'b010, 32'(4 * i), w[i]);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 3'b010, 32'(4 * i), 32'h0);
            n_tests++;
            if (got_rv !== 1'b1 || got_rd !== w[i]) begin
                n_fail++;
                $display("[TB] FAIL b2b_load%0d: rvalid=%b rdata=%h, expected 1 %h", i, got_rv, got_rd, w[i]);
            end
        end
        step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        n_tests++;
        if (got_rv !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_idle: rvalid=%b, expected 0", got_rv);
        end
    endtask

    task automatic test_random();
        logic [2:0]  store_codes [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
        logic [31:0] a, d, e_rd;
        logic [2:0]  f3;
        logic        w, e_rv, e_err;
        int          kind;
        ref_leds = 4'h0;
        for (int i = 0; i < 32; i++) begin
            d = $urandom;
            model_access(1'b1, 3'b010, 32'h80 + 32'(4 * i), d, e_rv, e_err, e_rd);
            step(1'b1, 1'b1, 3'b010, 32'h80 + 32'(4 * i), d);
        end
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 6)      a = 32'h80 + 32'($urandom_range(0, 127));
            else if (kind <= 8) a = BASE + 32'($urandom_range(0, 3));
            else                a = 32'h2000_0000 + 32'($urandom_range(0, 255));
            w  = 1'($urandom_range(0, 1));
            f3 = w ? store_codes[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            d  = $urandom;
            model_access(w, f3, a, d, e_rv, e_err, e_rd);
            step(1'b1, w, f3, a, d);
            n_tests++;
            if (got_rv !== e_rv || got_err !== e_err || got_rd !== e_rd || leds_out !== ref_leds) begin
                n_fail++;
                $display("[TB] FAIL random%0d we=%b f3=%b addr=%h: rvalid=%b err=%b rdata=%h leds=%h, expected %b %b %h %h",
                         i, w, f3, a, got_rv, got_err, got_rd, leds_out, e_rv, e_err, e_rd, ref_leds);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_ram_lanes();
        test_mmio_and_reset();
        test_counter();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
